// File: rtl/capture_ring_buffer.sv
// capture_ring_buffer
//   Multi-channel circular sample buffer with arm/trigger control and
//   pre/post-trigger capture. Once the capture completes the buffer freezes
//   and a registered readout port returns samples in logical order
//   (address 0 = oldest stored sample).
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   arm, post_count : start a new capture; post_count latched on arm
//   sample_valid    : sample_in carries a valid sample this cycle
//   sample_in       : CHANNELS packed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   trig            : trigger, qualified by sample_valid
//   rd_req, rd_ch,
//   rd_addr         : readout request (honoured only once capture is done)
//   rd_valid,
//   rd_data         : readout result, one cycle after rd_req
//   busy, done      : capture in progress / capture complete
//   sample_count    : number of valid stored samples (valid when done)
//   trig_index      : logical index of the trigger sample (valid when done)
module capture_ring_buffer #(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned ADDR_WIDTH = 8,
    parameter  int unsigned CHANNELS   = 2,
    localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           arm,
    input  logic [ADDR_WIDTH-1:0]          post_count,
    input  logic                           sample_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] sample_in,
    input  logic                           trig,
    input  logic                           rd_req,
    input  logic [CH_W-1:0]                rd_ch,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic                           rd_valid,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_WIDTH:0]            sample_count,
    output logic [ADDR_WIDTH-1:0]          trig_index
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q,        state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,       wr_ptr_d;
    logic                  wrapped_q,      wrapped_d;
    logic [ADDR_WIDTH-1:0] post_lat_q,     post_lat_d;
    logic [ADDR_WIDTH-1:0] post_cnt_q,     post_cnt_d;
    logic [ADDR_WIDTH:0]   sample_count_q, sample_count_d;
    logic [ADDR_WIDTH-1:0] trig_index_q,   trig_index_d;
    logic                  rd_valid_q;
    logic                  rd_ok_q;
    logic [CH_W-1:0]       rd_sel_q;

    logic                  wr_en;
    logic                  rd_en;
    logic                  rd_ch_ok;
    logic [ADDR_WIDTH-1:0] rd_phys;
    logic [ADDR_WIDTH-1:0] sc_low;
    logic [CHANNELS*DATA_WIDTH-1:0] rd_flat;

    assign wr_en   = !arm && sample_valid && ((state_q == S_ARMED) || (state_q == S_POST));
    assign rd_en   = rd_req && (state_q == S_DONE);
    // Oldest sample sits at wr_ptr once the ring has wrapped, else at 0.
    assign rd_phys = (wrapped_q ? wr_ptr_q : '0) + rd_addr;

    always_comb begin
        rd_ch_ok = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (rd_ch == CH_W'(c)) rd_ch_ok = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        wrapped_d      = wrapped_q;
        post_lat_d     = post_lat_q;
        post_cnt_d     = post_cnt_q;
        sample_count_d = sample_count_q;
        trig_index_d   = trig_index_q;

        if (arm) begin
            state_d        = S_ARMED;
            wr_ptr_d       = '0;
            wrapped_d      = 1'b0;
            // post_count cannot exceed depth-1 at this width, so the clamp is implicit.
            post_lat_d     = post_count;
            post_cnt_d     = '0;
            sample_count_d = '0;
            trig_index_d   = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (wr_ptr_q == '1) wrapped_d = 1'b1;
            if (state_q == S_ARMED) begin
                if (trig) begin
                    if (post_lat_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        post_cnt_d = post_lat_q;
                        state_d    = S_POST;
                    end
                end
            end else begin
                post_cnt_d = post_cnt_q - ADDR_WIDTH'(1);
                if (post_cnt_q == ADDR_WIDTH'(1)) state_d = S_DONE;
            end
        end

        // Capture summary is computed from the final write pointer on DONE entry.
        sc_low = wrapped_d ? '0 : wr_ptr_d;
        if (!arm && (state_d == S_DONE) && (state_q != S_DONE)) begin
            sample_count_d = {wrapped_d, sc_low};
            trig_index_d   = sc_low - post_lat_q - ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            wrapped_q      <= 1'b0;
            post_lat_q     <= '0;
            post_cnt_q     <= '0;
            sample_count_q <= '0;
            trig_index_q   <= '0;
            rd_valid_q     <= 1'b0;
            rd_ok_q        <= 1'b0;
            rd_sel_q       <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            wrapped_q      <= wrapped_d;
            post_lat_q     <= post_lat_d;
            post_cnt_q     <= post_cnt_d;
            sample_count_q <= sample_count_d;
            trig_index_q   <= trig_index_d;
            rd_valid_q     <= rd_en;
            if (rd_en) begin
                rd_ok_q  <= rd_ch_ok;
                rd_sel_q <= rd_ch;
            end
        end
    end

    // One simple dual-port RAM per channel; the read register lives next to
    // the array so it maps onto the RAM output register.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr_q] <= sample_in[c*DATA_WIDTH +: DATA_WIDTH];
            if (rd_en) rd_q <= mem[rd_phys];
        end

        assign rd_flat[c*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end

    // Select and flag are registered alongside the RAM read, so rd_data holds
    // between requests and reads 0 after reset or for a nonexistent channel.
    always_comb begin
        rd_data = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (rd_ok_q && (rd_sel_q == CH_W'(c))) rd_data = rd_flat[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rd_valid     = rd_valid_q;
    assign busy         = (state_q == S_ARMED) || (state_q == S_POST);
    assign done         = (state_q == S_DONE);
    assign sample_count = sample_count_q;
    assign trig_index   = trig_index_q;

endmodule

// File: tb/tb_capture_ring_buffer.sv
// Bench for capture_ring_buffer: directed scenarios with literal expectations
// plus a randomized phase, all compared each cycle against a queue-based model.
module tb_capture_ring_buffer;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic [3:0]  post_count;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        trig;
    logic        rd_req;
    logic        rd_ch;
    logic [3:0]  rd_addr;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic [4:0]  sample_count;
    logic [3:0]  trig_index;

    capture_ring_buffer #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .CHANNELS  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm         (arm),
        .post_count  (post_count),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .trig        (trig),
        .rd_req      (rd_req),
        .rd_ch       (rd_ch),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .sample_count(sample_count),
        .trig_index  (trig_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_state: 0 idle, 1 waiting for trigger, 2 post-trigger, 3 frozen
    int          m_state;
    int          n_wr;        // samples written since arm
    int          post_left;
    int          post_lat;
    int          trig_pos;    // global index (since arm) of the trigger sample
    logic [15:0] hist[$];     // last up-to-16 samples written, oldest first
    int          exp_cnt;
    int          exp_ti;
    logic        exp_rv;
    logic [7:0]  exp_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; n_wr = 0; post_left = 0; post_lat = 0; trig_pos = 0;
            hist.delete();
            exp_cnt = 0; exp_ti = 0; exp_rv = 1'b0; exp_rd = 8'h00;
        end else begin
            if (rd_req && m_state == 3) begin
                logic [15:0] w;
                w      = hist[rd_addr];
                exp_rv = 1'b1;
                exp_rd = rd_ch ? w[15:8] : w[7:0];
            end else begin
                exp_rv = 1'b0;
            end
            if (arm) begin
                m_state  = 1;
                n_wr     = 0;
                hist.delete();
                post_lat = (post_count > 15) ? 15 : int'(post_count);
                exp_cnt  = 0;
                exp_ti   = 0;
            end else if ((m_state == 1 || m_state == 2) && sample_valid) begin
                bit fin;
                fin = 1'b0;
                hist.push_back(sample_in);
                if (hist.size() > 16) void'(hist.pop_front());
                n_wr++;
                if (m_state == 1) begin
                    if (trig) begin
                        trig_pos = n_wr - 1;
                        if (post_lat == 0) fin = 1'b1;
                        else begin
                            m_state   = 2;
                            post_left = post_lat;
                        end
                    end
                end else begin
                    post_left--;
                    if (post_left == 0) fin = 1'b1;
                end
                if (fin) begin
                    m_state = 3;
                    exp_cnt = hist.size();
                    exp_ti  = trig_pos - (n_wr - hist.size());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("busy",         busy,         (m_state == 1 || m_state == 2));
            chk("done",         done,         (m_state == 3));
            chk("sample_count", sample_count, exp_cnt);
            chk("trig_index",   trig_index,   exp_ti);
            chk("rd_valid",     rd_valid,     exp_rv);
            chk("rd_data",      rd_data,      exp_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] smp(input int i);
        return {8'(8'h80 + i), 8'(i)};
    endfunction

    task automatic drive(input logic a, input logic [3:0] pc, input logic sv, input logic [15:0] si,
                         input logic t, input logic rr, input logic rc, input logic [3:0] ra);
        arm = a; post_count = pc; sample_valid = sv; sample_in = si;
        trig = t; rd_req = rr; rd_ch = rc; rd_addr = ra;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_arm(input logic [3:0] pc);
        drive(1'b1, pc, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic rd_lit(input string nm, input logic c, input logic [3:0] a, input logic [7:0] exp);
        drive(1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b1, c, a);
        chk({nm, "_valid"}, rd_valid, 1'b1);
        chk(nm, rd_data, exp);
    endtask

    task automatic run3(input string tag);
        do_arm(4'd2);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 4'h0, 1'b1, smp(i), (i == 3), 1'b0, 1'b0, 4'h0);
            if (i == 4) chk({tag, "_done_early"}, done, 1'b0);
        end
        chk({tag, "_done"},  done, 1'b1);
        chk({tag, "_count"}, sample_count, 5'd6);
        chk({tag, "_tidx"},  trig_index, 4'd3);
        rd_lit({tag, "_a0"}, 1'b0, 4'd0, 8'd0);
        rd_lit({tag, "_a5"}, 1'b0, 4'd5, 8'd5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        arm = 0; post_count = 0; sample_valid = 0; sample_in = 0;
        trig = 0; rd_req = 0; rd_ch = 0; rd_addr = 0;
        #1 rst_n = 1'b0;
        #7;
        chk("rst_busy",  busy, 1'b0);
        chk("rst_done",  done, 1'b0);
        chk("rst_count", sample_count, 5'd0);
        chk("rst_tidx",  trig_index, 4'd0);
        chk("rst_rv",    rd_valid, 1'b0);
        chk("rst_rd",    rd_data, 8'd0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Idle: samples and trigger ignored
        drive(1'b0, 4'h0, 1'b1, smp(1), 1'b1, 1'b0, 1'b0, 4'h0);
        chk("idle_busy", busy, 1'b0);

        // 1: wrap-around capture, trigger at 20, 4 post samples
        do_arm(4'd4);
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 4'h0, 1'b1, smp(i), (i == 20), 1'b0, 1'b0, 4'h0);
            if (i == 23) chk("s1_done_early", done, 1'b0);
            if (i == 24) chk("s1_done_at24", done, 1'b1);
        end
        chk("s1_count", sample_count, 5'd16);
        chk("s1_tidx",  trig_index, 4'd11);
        rd_lit("s1_c0a0",  1'b0, 4'd0,  8'd9);
        rd_lit("s1_c0a11", 1'b0, 4'd11, 8'd20);
        rd_lit("s1_c0a15", 1'b0, 4'd15, 8'd24);
        rd_lit("s1_c1a15", 1'b1, 4'd15, 8'h98);
        drive(1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("s1_rv_drop", rd_valid, 1'b0);
        chk("s1_rd_hold", rd_data, 8'h98);

        // 2: no trigger, capture never ends
        do_arm(4'd4);
        for (int i = 0; i < 50; i++) drive(1'b0, 4'h0, 1'b1, smp(i), 1'b0, 1'b0, 1'b0, 4'h0);
        chk("s2_busy", busy, 1'b1);
        chk("s2_done", done, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 4'h0);
        chk("s2_rv", rd_valid, 1'b0);

        // 3: short capture without wrap
        run3("s3");

        // 4a: immediate completion
        do_arm(4'd0);
        drive(1'b0, 4'h0, 1'b1, smp(0), 1'b1, 1'b0, 1'b0, 4'h0);
        chk("s4a_done",  done, 1'b1);
        chk("s4a_count", sample_count, 5'd1);
        chk("s4a_tidx",  trig_index, 4'd0);
        rd_lit("s4a_a0", 1'b0, 4'd0, 8'd0);

        // 4b: largest post_count representable at this width
        do_arm(4'd15);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'h0, 1'b1, smp(i), (i == 0), 1'b0, 1'b0, 4'h0);
            if (i == 14) chk("s4b_done_early", done, 1'b0);
        end
        chk("s4b_done",  done, 1'b1);
        chk("s4b_count", sample_count, 5'd16);
        chk("s4b_tidx",  trig_index, 4'd0);
        rd_lit("s4b_a0", 1'b0, 4'd0, 8'd0);

        // 5: gapped samples, trigger without valid ignored
        do_arm(4'd1);
        for (int c = 0; c < 7; c++) begin
            logic sv;
            logic t;
            sv = (c % 2 == 0);
            t  = (c == 1) || (c == 4);
            drive(1'b0, 4'h0, sv, smp(c / 2), t, 1'b0, 1'b0, 4'h0);
        end
        chk("s5_done",  done, 1'b1);
        chk("s5_count", sample_count, 5'd4);
        chk("s5_tidx",  trig_index, 4'd2);
        // arm with trigger and sample in the same cycle: nothing written
        drive(1'b1, 4'd0, 1'b1, smp(99), 1'b1, 1'b0, 1'b0, 4'h0);
        chk("s5_arm_busy",  busy, 1'b1);
        chk("s5_arm_count", sample_count, 5'd0);
        drive(1'b0, 4'h0, 1'b1, 16'h9010, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("s5_one_count", sample_count, 5'd1);
        rd_lit("s5_c0", 1'b0, 4'd0, 8'h10);
        rd_lit("s5_c1", 1'b1, 4'd0, 8'h90);

        // 6: asynchronous reset mid-POST
        do_arm(4'd2);
        for (int i = 0; i < 5; i++) drive(1'b0, 4'h0, 1'b1, smp(i), (i == 3), 1'b0, 1'b0, 4'h0);
        chk("s6_busy_pre", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_busy",  busy, 1'b0);
        chk("s6_done",  done, 1'b0);
        chk("s6_rv",    rd_valid, 1'b0);
        chk("s6_count", sample_count, 5'd0);
        chk("s6_tidx",  trig_index, 4'd0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b1, smp(i), 1'b1, 1'b0, 1'b0, 4'h0);
        chk("s6_ign_busy", busy, 1'b0);
        chk("s6_ign_done", done, 1'b0);
        run3("s6r");

        // Randomized phase against the model
        for (int k = 0; k < 3000; k++) begin
            logic        a;
            logic [3:0]  ra;
            a  = ($urandom_range(0, 59) == 0) || (m_state == 0 && $urandom_range(0, 3) == 0);
            ra = (m_state == 3) ? 4'($urandom_range(0, exp_cnt - 1)) : 4'($urandom_range(0, 15));
            drive(a, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ra);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
